ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port imem_req  output  1  fetch request valid.
REQ-007 SHALL have port imem_addr  output  32  fetch word address.
REQ-008 SHALL have port imem_ready  input  1  memory accepts request this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  read data valid; responses in request order, latency >= 1 cycle.
REQ-010 SHALL have port imem_rdata  input  32  instruction word.
REQ-011 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc  input  32  new fetch address.
REQ-013 SHALL have port i_valid  output  1  instruction available to CPU.
REQ-014 SHALL have port i_datain  output  32  instruction to CPU (head entry).
REQ-015 SHALL have port i_pc  output  32  address of head instruction.
REQ-016 SHALL have port i_ready  input  1  CPU consumes head this cycle.
REQ-017 SHALL have port err  output  1  sticky: response received with no live or stale request outstanding.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, FLUSH; IDLE -> FETCH unconditionally after one cycle.
REQ-019 SHALL, in FETCH, assert imem_req when occupancy + outstanding < DEPTH and redirect = 0; imem_req = 0 in IDLE and FLUSH.
REQ-020 SHALL count a request as issued only when imem_req && imem_ready; then fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 SHALL hold imem_req and imem_addr stable while imem_req && !imem_ready, except when redirect asserts.
REQ-022 SHALL push {imem_rdata, resp_pc} at tail on each live imem_rvalid; resp_pc starts at the fetch address and increments by 4 per live response.
REQ-023 SHALL drive i_valid = (occupancy != 0) && !redirect; i_datain/i_pc = head entry; pop on i_valid && i_ready.
REQ-024 SHALL allow push and pop in the same cycle with occupancy unchanged; no bypass: a response written into an empty queue gives i_valid the next cycle.
REQ-025 SHALL give latency from request acceptance to i_valid of memory latency + 1 cycle.
REQ-026 SHALL never overflow; credit rule REQ-019 guarantees space for every outstanding response.
REQ-027 SHALL treat redirect as highest priority: same cycle the queue is cleared, pop ignored, no request issued, live outstanding count moved into stale count, and fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}.
REQ-028 SHALL count a response arriving in the redirect cycle as stale and discard it.
REQ-029 SHALL, after redirect, enter FLUSH if stale count > 0, else FETCH; FLUSH discards each imem_rvalid, decrementing stale; stale reaching 0 -> FETCH next cycle.
REQ-030 SHALL accept redirect in FLUSH: adopt the new redirect_pc, keep remaining stale count, stay in FLUSH.
REQ-031 SHALL set err on imem_rvalid when live and stale counts are both 0, and drop that data; err clears only on reset.

Reset
REQ-032 SHALL, while reset = 1, asynchronously force state IDLE, fetch_pc = resp_pc = RESET_PC, occupancy/outstanding/stale = 0, imem_req = 0, imem_addr = RESET_PC, i_valid = 0, i_datain = 0, i_pc = 0, err = 0.
REQ-033 SHALL, on reset mid-operation, discard all queued and outstanding state; responses arriving after release with nothing outstanding set err.

Verification
REQ-034 SHALL cover: reset release, imem_ready=1, 1-cycle memory returning words 8C01_0001, 8C02_0002 -> i_valid at cycle 3 with i_pc=0, i_datain=8C01_0001, then i_pc=4.
REQ-035 SHALL cover: i_ready=0 always, DEPTH=4 -> exactly 4 requests (0,4,8,C), imem_req then 0, occupancy 4; one pop -> request to 10.
REQ-036 SHALL cover: 2 requests outstanding, redirect with redirect_pc=32'h0000_0042 -> FLUSH, both responses dropped, next imem_addr = 40, first i_pc = 40.
REQ-037 SHALL cover: imem_ready low 3 cycles at addr 8 -> imem_req/imem_addr held at 1/8 until accepted.
REQ-038 SHALL cover: fetch_pc = FFFF_FFFC accepted -> next imem_addr = 0.
REQ-039 SHALL cover: imem_rvalid with nothing outstanding -> err = 1, queue unchanged, err held until reset.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-based request issue, in-order response capture,
// redirect flush with stale-response accounting and a sticky protocol error flag.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        i_valid,
    output logic [31:0] i_datain,
    output logic [31:0] i_pc,
    input  logic        i_ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic          issue;
    logic          pop;
    logic          live_rsp;
    logic          err_set;
    logic          not_empty;
    logic [CW-1:0] stale_nxt;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_aligned;

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign credit_used      = {1'b0, occupancy} + {1'b0, outstanding};
    assign not_empty        = (occupancy != '0);

    // Credits cover both queued entries and responses still in flight, so a
    // response always finds a free slot.
    assign imem_req  = (state == FETCH) && !redirect && (credit_used < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_ready;

    assign i_valid  = not_empty && !redirect;
    assign i_datain = not_empty ? q_data[head] : '0;
    assign i_pc     = not_empty ? q_pc[head]   : '0;
    assign pop      = i_valid && i_ready;

    // Classify the incoming response: stale requests are always older than live
    // ones, so stale responses are consumed first.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        live_rsp  = 1'b0;
        err_set   = 1'b0;
        stale_nxt = stale;
        if (redirect) begin
            stale_nxt = stale + outstanding;
            if (imem_rvalid) begin
                if (stale_nxt == '0) err_set = 1'b1;
                else                 stale_nxt = stale_nxt - CW'(1);
            end
        end else if (imem_rvalid) begin
            if (stale != '0)            stale_nxt = stale - CW'(1);
            else if (outstanding != '0) live_rsp  = 1'b1;
            else                        err_set   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            occupancy   <= '0;
            outstanding <= '0;
            stale       <= '0;
            head        <= '0;
            tail        <= '0;
            err         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            err   <= err | err_set;
            stale <= stale_nxt;
            state <= (stale_nxt != '0) ? FLUSH : FETCH;
            if (redirect) begin
                fetch_pc    <= redirect_aligned;
                resp_pc     <= redirect_aligned;
                occupancy   <= '0;
                outstanding <= '0;
                head        <= '0;
                tail        <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (live_rsp) begin
                    resp_pc <= resp_pc + 32'd4;
                    tail    <= tail + AW'(1);
                end
                if (pop) head <= head + AW'(1);
                occupancy   <= occupancy + CW'(live_rsp) - CW'(pop);
                outstanding <= outstanding + CW'(issue) - CW'(live_rsp);
            end
        end
    end

    // NOTE: queue storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (live_rsp) begin
            q_data[tail] <= imem_rdata;
            q_pc[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: in-order memory model, scoreboard of
// expected {pc, word} pairs, a redirect vector table and hand-written corner cases.
module tb_ifetch_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        i_valid;
    logic [31:0] i_datain;
    logic [31:0] i_pc;
    logic        i_ready;
    logic        err;

    always #5 clock = ~clock;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .i_valid    (i_valid),
        .i_datain   (i_datain),
        .i_pc       (i_pc),
        .i_ready    (i_ready),
        .err        (err)
    );

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct {
        logic [31:0] target;
        bit          second;
        logic [31:0] target2;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } redir_vec_t;

    mem_req_t    pending[$];
    exp_t        sb[$];
    logic [31:0] pop_log[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc;
    int          lat;
    int          n_acc;
    int          first_valid;
    logic [31:0] exp_fetch;
    logic        mem_ready, cpu_ready, redir, inject;
    logic [31:0] redir_target;
    logic        s_req, s_valid, s_err;
    logic [31:0] s_addr, s_pc, s_data;
    logic        prev_stall;
    logic [31:0] prev_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [15:0] k;
        k = a[17:2] + 16'd1;
        return {8'h8C, k[7:0], k};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One clock: drive inputs just after a falling edge, sample outputs 1 time unit later.
    task automatic cycle();
        imem_ready  = mem_ready;
        i_ready     = cpu_ready;
        redirect    = redir;
        redirect_pc = redir_target;
        if (inject) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (pending.size() != 0 && pending[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pending[0].addr);
            pending.delete(0);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = i_valid;
        s_pc = i_pc; s_data = i_datain; s_err = err;
        if (prev_stall && !redirect) begin
            check("hold_req", imem_req, 1'b1);
            check("hold_addr", imem_addr, prev_addr);
        end
        if (redirect) check("req_low_on_redirect", imem_req, 1'b0);
        if (imem_req && imem_ready) begin
            check("imem_addr", imem_addr, exp_fetch);
            pending.push_back('{addr: imem_addr, due: cyc + lat});
            sb.push_back('{pc: exp_fetch, data: word_of(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
            n_acc++;
        end
        if (i_valid && first_valid < 0) first_valid = cyc;
        if (i_valid && i_ready) begin
            check("pop_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                check("i_pc", i_pc, sb[0].pc);
                check("i_datain", i_datain, sb[0].data);
                sb.delete(0);
            end
            pop_log.push_back(i_pc);
        end
        if (redirect) begin
            sb.delete();
            pop_log.delete();
            exp_fetch = redir_target & 32'hFFFF_FFFC;
        end
        prev_stall = imem_req && !imem_ready;
        prev_addr  = imem_addr;
        @(negedge clock);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input bit keep_pending);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_ready  = 1'b0;
        i_ready     = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_i_valid", i_valid, 1'b0);
        check("rst_i_datain", i_datain, 32'h0);
        check("rst_i_pc", i_pc, 32'h0);
        check("rst_err", err, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cyc = 0; n_acc = 0; first_valid = -1; exp_fetch = 32'h0;
        prev_stall = 1'b0; prev_addr = '0;
        sb.delete();
        pop_log.delete();
        if (keep_pending) begin
            foreach (pending[i]) pending[i].due = 0;
        end else begin
            pending.delete();
        end
        mem_ready = 1'b1; cpu_ready = 1'b1; redir = 1'b0; inject = 1'b0;
        lat = 1; redir_target = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary line");
        $fatal(1);
    end

    initial begin
        redir_vec_t vecs[5];
        vecs[0] = '{32'h0000_0042, 1'b0, 32'h0,         32'h0000_0040, 32'h0000_0044};
        vecs[1] = '{32'h0000_0103, 1'b0, 32'h0,         32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFE, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h0000_0042, 1'b1, 32'h0000_0201, 32'h0000_0200, 32'h0000_0204};
        vecs[4] = '{32'h1234_5679, 1'b0, 32'h0,         32'h1234_5678, 32'h1234_567C};

        reset = 1'b0;
        #2;

        // Basic streaming with a 1-cycle memory: first instruction visible at cycle 3.
        do_reset(1'b0);
        run(3);
        check("t1_no_valid_early", s_valid, 1'b0);
        cycle();
        check("t1_valid_c3", s_valid, 1'b1);
        check("t1_pc0", s_pc, 32'h0);
        check("t1_data0", s_data, 32'h8C01_0001);
        cycle();
        check("t1_pc1", s_pc, 32'h4);
        check("t1_data1", s_data, 32'h8C02_0002);
        check("t1_first_valid_cycle", first_valid, 32'd3);

        // Random back-pressure on both sides with a 2-cycle memory.
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            cpu_ready = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        // Reset with responses still in flight: they return after release and set err.
        lat = 3; mem_ready = 1'b1; cpu_ready = 1'b1;
        run(4);
        do_reset(1'b1);
        mem_ready = 1'b0;
        run(3);
        check("t1_err_after_midop_reset", s_err, 1'b1);
        check("t1_no_valid_after_midop_reset", s_valid, 1'b0);

        // CPU stalled: exactly DEPTH requests, then one pop frees a credit for 0x10.
        do_reset(1'b0);
        cpu_ready = 1'b0;
        run(12);
        check("t2_n_acc", n_acc, 32'd4);
        check("t2_req_low_full", s_req, 1'b0);
        check("t2_valid_full", s_valid, 1'b1);
        check("t2_head_pc", s_pc, 32'h0);
        cpu_ready = 1'b1;
        cycle();
        cpu_ready = 1'b0;
        cycle();
        check("t2_req_after_pop", s_req, 1'b1);
        check("t2_addr_after_pop", s_addr, 32'h10);
        run(3);
        check("t2_n_acc_after_pop", n_acc, 32'd5);

        // Memory not ready for 3 cycles at address 8: request held until accepted.
        do_reset(1'b0);
        run(3);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t3_req_held", s_req, 1'b1);
            check("t3_addr_held", s_addr, 32'h8);
        end
        mem_ready = 1'b1;
        cycle();
        check("t3_accept_addr", s_addr, 32'h8);
        run(10);

        // Redirect table: two requests in flight, flush, refetch from aligned target.
        foreach (vecs[v]) begin
            do_reset(1'b0);
            lat = 3;
            run(3);
            redir = 1'b1; redir_target = vecs[v].target;
            cycle();
            redir = 1'b0;
            if (vecs[v].second) begin
                redir = 1'b1; redir_target = vecs[v].target2;
                cycle();
                redir = 1'b0;
            end
            while (cyc < 6) begin
                cycle();
                check("t4_flush_req_low", s_req, 1'b0);
                check("t4_flush_valid_low", s_valid, 1'b0);
            end
            cycle();
            check("t4_refetch_req", s_req, 1'b1);
            check("t4_refetch_addr", s_addr, vecs[v].exp_pc0);
            run(8);
            check("t4_two_pops", pop_log.size() >= 2, 1'b1);
            if (pop_log.size() >= 2) begin
                check("t4_first_pc", pop_log[0], vecs[v].exp_pc0);
                check("t4_second_pc", pop_log[1], vecs[v].exp_pc1);
            end
        end

        // Spurious response with nothing outstanding: err sticks, queue untouched.
        do_reset(1'b0);
        cpu_ready = 1'b0; mem_ready = 1'b0;
        cycle();
        mem_ready = 1'b1;
        cycle();
        mem_ready = 1'b0;
        run(2);
        check("t5_valid_before", s_valid, 1'b1);
        check("t5_err_before", s_err, 1'b0);
        inject = 1'b1;
        cycle();
        inject = 1'b0;
        check("t5_err_same_cycle", s_err, 1'b0);
        cycle();
        check("t5_err_set", s_err, 1'b1);
        check("t5_head_pc", s_pc, 32'h0);
        check("t5_head_data", s_data, 32'h8C01_0001);
        cpu_ready = 1'b1;
        cycle();
        cycle();
        check("t5_queue_unchanged", s_valid, 1'b0);
        run(5);
        check("t5_err_sticky", s_err, 1'b1);
        do_reset(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
